// File: rtl/mac_sched.sv
// Round-robin scheduler feeding one shared three-beat MAC datapath from two requesters.
// Optional macro MAC_SCHED_CHECK_EN enables missing/unexpected-result checking on rsp_err.
module mac_sched #(
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [1:0]     req_valid,
  input  logic [2*W-1:0] req_a,
  input  logic [2*W-1:0] req_b,
  input  logic [2*W-1:0] req_c,
  output logic [1:0]     req_ready,
  output logic           validi,
  output logic [W-1:0]   data_in,
  input  logic           valido,
  input  logic [W-1:0]   data_out,
  output logic           rsp_valid,
  output logic           rsp_id,
  output logic [W-1:0]   rsp_data,
  output logic           rsp_err
);

  typedef enum logic [2:0] {IDLE, BEAT_A, BEAT_B, BEAT_C, WAIT} state_t;

  state_t         state, state_nxt;
  logic           last_grant;
  logic [W-1:0]   op_a, op_b, op_c;
  logic           op_id;
  logic           arb_open;
  logic           grant;
  logic           winner;
  logic [W-1:0]   wait_data;

  // Arbitration is only open in IDLE/WAIT; WAIT's single idle beat keeps validi runs at three.
  always_comb begin
    state_nxt = state;
    validi    = 1'b0;
    data_in   = '0;
    req_ready = 2'b00;
    arb_open  = 1'b0;
    winner    = (req_valid == 2'b11) ? ~last_grant : req_valid[1];
    case (state)
      IDLE:   arb_open = 1'b1;
      BEAT_A: begin validi = 1'b1; data_in = op_a; state_nxt = BEAT_B; end
      BEAT_B: begin validi = 1'b1; data_in = op_b; state_nxt = BEAT_C; end
      BEAT_C: begin validi = 1'b1; data_in = op_c; state_nxt = WAIT;   end
      WAIT:   begin arb_open = 1'b1; state_nxt = IDLE; end
      default: state_nxt = IDLE;
    endcase
    grant = arb_open && (req_valid != 2'b00) && !rst;
    if (grant) begin
      state_nxt = BEAT_A;
      req_ready = winner ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      op_a       <= '0;
      op_b       <= '0;
      op_c       <= '0;
      op_id      <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_data   <= '0;
    end else begin
      state     <= state_nxt;
      rsp_valid <= (state == WAIT);
      if (grant) begin
        last_grant <= winner;
        op_id      <= winner;
        op_a       <= winner ? req_a[W +: W] : req_a[0 +: W];
        op_b       <= winner ? req_b[W +: W] : req_b[0 +: W];
        op_c       <= winner ? req_c[W +: W] : req_c[0 +: W];
      end
      if (state == WAIT) begin
        rsp_id   <= op_id;
        rsp_data <= wait_data;
      end
    end
  end

`ifdef MAC_SCHED_CHECK_EN
  logic stray_seen;

  assign wait_data = valido ? data_out : '0;

  // A result outside WAIT is flagged on the next response issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      stray_seen <= 1'b0;
      rsp_err    <= 1'b0;
    end else if (state == WAIT) begin
      rsp_err    <= !valido || stray_seen;
      stray_seen <= 1'b0;
    end else if (valido) begin
      stray_seen <= 1'b1;
    end
  end
`else
  logic unused_valido;

  assign wait_data     = data_out;
  assign rsp_err       = 1'b0;
  assign unused_valido = valido;
`endif

endmodule

// File: tb/tb_mac_sched.sv
// Directed bench for mac_sched with a behavioural three-beat MAC datapath model.
module tb_mac_sched;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [1:0]     req_valid = 2'b11;
  logic [2*W-1:0] req_a = '0, req_b = '0, req_c = '0;
  logic [1:0]     req_ready;
  logic           validi;
  logic [W-1:0]   data_in;
  logic           valido;
  logic [W-1:0]   data_out;
  logic           rsp_valid;
  logic           rsp_id;
  logic [W-1:0]   rsp_data;
  logic           rsp_err;

  int   vectors = 0;
  int   miscompares = 0;
  logic suppress = 1'b0;

  logic [1:0]   beat_cnt;
  logic [W-1:0] ma, mb;

  always #5 clk = ~clk;

  mac_sched #(.W(W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_c(req_c),
    .req_ready(req_ready), .validi(validi), .data_in(data_in), .valido(valido),
    .data_out(data_out), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_err(rsp_err)
  );

  // Datapath model: result (a*b+c mod 2^W) and valido one cycle after the third beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt <= 2'd0;
      valido   <= 1'b0;
      data_out <= '0;
      ma       <= '0;
      mb       <= '0;
    end else begin
      valido <= 1'b0;
      if (validi) begin
        case (beat_cnt)
          2'd0: ma <= data_in;
          2'd1: mb <= data_in;
          default: begin
            data_out <= ma * mb + data_in;
            valido   <= !suppress;
          end
        endcase
        beat_cnt <= (beat_cnt == 2'd2) ? 2'd0 : beat_cnt + 2'd1;
      end else begin
        beat_cnt <= 2'd0;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] c);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_c[i*W +: W] = c;
  endtask

  task automatic test_reset;
    set_req(0, 32'd9, 32'd9, 32'd9);
    set_req(1, 32'd7, 32'd7, 32'd7);
    req_valid = 2'b11;
    rst = 1'b1;
    tick;
    #1;
    vectors++;
    if (req_ready !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL reset_ready_gate: got %b expected 00", req_ready);
    end
    tick;
    #1;
    vectors++;
    if ({req_ready, validi, rsp_valid, rsp_id, rsp_err} !== 6'b0 || data_in !== '0 || rsp_data !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got ready=%b validi=%b data_in=%0h rsp_valid=%b rsp_id=%b rsp_data=%0h rsp_err=%b expected all 0",
               req_ready, validi, data_in, rsp_valid, rsp_id, rsp_data, rsp_err);
    end
    rst = 1'b0;
    #1;
    vectors++;
    if (req_ready !== 2'b01) begin
      miscompares++;
      $display("[TB] FAIL reset_first_grant: got %b expected 01", req_ready);
    end
    req_valid = 2'b00;
  endtask

  task automatic test_single;
    logic [W-1:0] exp_beat [3];
    exp_beat[0] = 32'd3;
    exp_beat[1] = 32'd4;
    exp_beat[2] = 32'd5;
    tick;
    set_req(0, 32'd3, 32'd4, 32'd5);
    req_valid = 2'b01;
    #1;
    vectors++;
    if (req_ready !== 2'b01) begin
      miscompares++;
      $display("[TB] FAIL single_accept: got %b expected 01", req_ready);
    end
    for (int k = 1; k <= 5; k++) begin
      tick;
      req_valid = 2'b00;
      #1;
      vectors++;
      if (k <= 3 && (validi !== 1'b1 || data_in !== exp_beat[k-1])) begin
        miscompares++;
        $display("[TB] FAIL single_beat%0d: got validi=%b data_in=%0h expected 1/%0h",
                 k, validi, data_in, exp_beat[k-1]);
      end
      if (k >= 4 && validi !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL single_gap%0d: got validi=%b expected 0", k, validi);
      end
      if (rsp_valid !== (k == 5)) begin
        miscompares++;
        $display("[TB] FAIL single_rsp_valid%0d: got %b expected %b", k, rsp_valid, (k == 5));
      end
    end
    vectors++;
    if (rsp_id !== 1'b0 || rsp_data !== 32'd17 || rsp_err !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL single_rsp: got id=%b data=%0d err=%b expected 0/17/0", rsp_id, rsp_data, rsp_err);
    end
    tick;
    #1;
    vectors++;
    if (rsp_valid !== 1'b0 || rsp_data !== 32'd17) begin
      miscompares++;
      $display("[TB] FAIL single_rsp_hold: got valid=%b data=%0d expected 0/17", rsp_valid, rsp_data);
    end
  endtask

  task automatic test_back_to_back;
    int run;
    logic [1:0] exp_ready;
    logic exp_validi, exp_rsp, gid;
    logic [W-1:0] exp_din;
    run = 0;
    rst = 1'b1;
    req_valid = 2'b00;
    tick;
    rst = 1'b0;
    set_req(0, 32'd1, 32'd2, 32'd3);
    set_req(1, 32'd2, 32'd2, 32'd2);
    req_valid = 2'b11;
    for (int k = 0; k <= 18; k++) begin
      if (k > 0) begin
        tick;
        if (k == 13) req_valid = 2'b00;
      end
      #1;
      exp_ready  = (k % 4 == 0 && k <= 12) ? (((k / 4) % 2 == 1) ? 2'b10 : 2'b01) : 2'b00;
      exp_validi = (k >= 1 && k <= 15 && k % 4 != 0);
      gid        = ((k - 1) / 4) % 2 == 1;
      exp_din    = exp_validi ? (gid ? 32'd2 : 32'((k - 1) % 4 + 1)) : 32'd0;
      exp_rsp    = (k >= 5 && k % 4 == 1);
      vectors++;
      if (req_ready !== exp_ready) begin
        miscompares++;
        $display("[TB] FAIL b2b_ready@%0d: got %b expected %b", k, req_ready, exp_ready);
      end
      vectors++;
      if (validi !== exp_validi || data_in !== exp_din) begin
        miscompares++;
        $display("[TB] FAIL b2b_beat@%0d: got validi=%b data_in=%0h expected %b/%0h",
                 k, validi, data_in, exp_validi, exp_din);
      end
      run = validi ? run + 1 : 0;
      vectors++;
      if (run > 3) begin
        miscompares++;
        $display("[TB] FAIL b2b_run@%0d: got run %0d expected at most 3", k, run);
      end
      vectors++;
      if (rsp_valid !== exp_rsp) begin
        miscompares++;
        $display("[TB] FAIL b2b_rsp_valid@%0d: got %b expected %b", k, rsp_valid, exp_rsp);
      end else if (exp_rsp) begin
        gid = ((k - 5) / 4) % 2 == 1;
        if (rsp_id !== gid || rsp_data !== (gid ? 32'd6 : 32'd5)) begin
          miscompares++;
          $display("[TB] FAIL b2b_rsp@%0d: got id=%b data=%0d expected %b/%0d",
                   k, rsp_id, rsp_data, gid, gid ? 6 : 5);
        end
      end
    end
  endtask

  task automatic test_wrap;
    tick;
    set_req(1, 32'hFFFF_FFFF, 32'd2, 32'd3);
    req_valid = 2'b10;
    #1;
    vectors++;
    if (req_ready !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL wrap_accept: got %b expected 10", req_ready);
    end
    for (int k = 1; k <= 5; k++) begin
      tick;
      req_valid = 2'b00;
    end
    #1;
    vectors++;
    if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_data !== 32'h0000_0001) begin
      miscompares++;
      $display("[TB] FAIL wrap_rsp: got valid=%b id=%b data=%0h expected 1/1/1", rsp_valid, rsp_id, rsp_data);
    end
  endtask

  task automatic test_reset_mid_op;
    tick;
    set_req(1, 32'd7, 32'd8, 32'd9);
    set_req(0, 32'd1, 32'd1, 32'd1);
    req_valid = 2'b10;
    #1;
    vectors++;
    if (req_ready !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL mid_accept: got %b expected 10", req_ready);
    end
    tick;
    req_valid = 2'b00;
    tick;
    #1;
    vectors++;
    if (validi !== 1'b1 || data_in !== 32'd8) begin
      miscompares++;
      $display("[TB] FAIL mid_beat_b: got validi=%b data_in=%0h expected 1/8", validi, data_in);
    end
    rst = 1'b1;
    req_valid = 2'b11;
    tick;
    rst = 1'b0;
    #1;
    vectors++;
    if (validi !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 2'b01) begin
      miscompares++;
      $display("[TB] FAIL mid_after_reset: got validi=%b rsp_valid=%b ready=%b expected 0/0/01",
               validi, rsp_valid, req_ready);
    end
    for (int k = 4; k <= 8; k++) begin
      tick;
      req_valid = 2'b00;
      #1;
      vectors++;
      if (rsp_valid !== (k == 8)) begin
        miscompares++;
        $display("[TB] FAIL mid_rsp_valid@%0d: got %b expected %b", k, rsp_valid, (k == 8));
      end
    end
    vectors++;
    if (rsp_id !== 1'b0 || rsp_data !== 32'd2) begin
      miscompares++;
      $display("[TB] FAIL mid_rsp: got id=%b data=%0d expected 0/2", rsp_id, rsp_data);
    end
  endtask

`ifdef MAC_SCHED_CHECK_EN
  task automatic test_check_err;
    for (int n = 0; n < 2; n++) begin
      suppress = (n == 0);
      tick;
      set_req(0, 32'd2, 32'd3, 32'd4);
      req_valid = 2'b01;
      for (int k = 1; k <= 5; k++) begin
        tick;
        req_valid = 2'b00;
      end
      #1;
      vectors++;
      if (rsp_valid !== 1'b1 || rsp_err !== (n == 0) || rsp_data !== ((n == 0) ? 32'd0 : 32'd10)) begin
        miscompares++;
        $display("[TB] FAIL check_err%0d: got valid=%b err=%b data=%0d expected 1/%b/%0d",
                 n, rsp_valid, rsp_err, rsp_data, (n == 0), (n == 0) ? 0 : 10);
      end
    end
    suppress = 1'b0;
  endtask
`endif

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_wrap;
    test_reset_mid_op;
`ifdef MAC_SCHED_CHECK_EN
    test_check_err;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
